// File: rtl/pong_pkg.sv
// Shared constants and helpers for the Pong datapath.
// Screen geometry, play-field limits, defaults, colours.
package pong_pkg;
  localparam int SCR_W      = 160;
  localparam int SCR_H      = 120;
  localparam int PAD_W      = 2;
  localparam int LPAD_X     = 4;
  localparam int RPAD_X     = 154;
  localparam int PAD_Y_MAX  = 104;
  localparam int BALL_Y_MAX = 116;
  localparam int BALL_X_MAX = 156;
  localparam int LHIT_X     = LPAD_X + PAD_W;
  localparam int PAD_Y0     = 52;
  localparam int BALL_X0    = 78;
  localparam int BALL_Y0    = 58;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  function automatic logic [6:0] pad_next(
    input logic [6:0] y,
    input logic       up,
    input logic       dn,
    input int         step
  );
    int t;
    t = {25'd0, y};
    if (up && !dn)
      t = (t < step) ? 0 : t - step;
    else if (dn && !up)
      t = (t + step > PAD_Y_MAX) ?
          PAD_Y_MAX : t + step;
    return t[6:0];
  endfunction
endpackage

// File: rtl/pong_if.sv
// Control-FSM to datapath bundle: strobes and buttons in,
// pixel stream and miss flag out.
interface pong_if;
  logic       menu;
  logic       move_pads;
  logic       move_ball;
  logic       set_up_clear_screen;
  logic       clear_screen;
  logic       load_left_pad;
  logic       draw_left_pad;
  logic       load_right_pad;
  logic       draw_right_pad;
  logic       load_ball;
  logic       draw_ball;
  logic       reset_delta;
  logic       l_up;
  logic       l_down;
  logic       r_up;
  logic       r_down;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       gameover;

  modport master (
    output menu, move_pads, move_ball,
    output set_up_clear_screen, clear_screen,
    output load_left_pad, draw_left_pad,
    output load_right_pad, draw_right_pad,
    output load_ball, draw_ball, reset_delta,
    output l_up, l_down, r_up, r_down,
    input  x, y, colour, gameover
  );

  modport slave (
    input  menu, move_pads, move_ball,
    input  set_up_clear_screen, clear_screen,
    input  load_left_pad, draw_left_pad,
    input  load_right_pad, draw_right_pad,
    input  load_ball, draw_ball, reset_delta,
    input  l_up, l_down, r_up, r_down,
    output x, y, colour, gameover
  );
endinterface

// File: rtl/pong_datapath_pixel_scanner.sv
// Raster scanner: latches a rectangle and walks it
// one pixel per draw cycle, saturating at the last pixel.
module pixel_scanner (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_zero,
  input  logic       i_load,
  input  logic [7:0] i_bx,
  input  logic [6:0] i_by,
  input  logic [7:0] i_w,
  input  logic [6:0] i_h,
  input  logic [2:0] i_col,
  input  logic       i_clr,
  input  logic       i_draw,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic [2:0] o_colour
);
  logic [7:0] r_bx, r_w, r_ox;
  logic [6:0] r_by, r_h, r_oy;
  logic [2:0] r_col;
  logic       w_x_more, w_y_more;

  // compare with +1 so a zero-size shape just holds
  assign w_x_more = ({1'b0, r_ox} + 9'd1) < {1'b0, r_w};
  assign w_y_more = ({1'b0, r_oy} + 8'd1) < {1'b0, r_h};

  // shape registers and raster offsets; load beats draw
  always_ff @(posedge clk) begin
    if (!resetn || i_zero) begin
      r_bx  <= '0;
      r_by  <= '0;
      r_w   <= '0;
      r_h   <= '0;
      r_col <= '0;
      r_ox  <= '0;
      r_oy  <= '0;
    end else if (i_load) begin
      r_bx  <= i_bx;
      r_by  <= i_by;
      r_w   <= i_w;
      r_h   <= i_h;
      r_col <= i_col;
      r_ox  <= '0;
      r_oy  <= '0;
    end else if (i_clr) begin
      r_ox <= '0;
      r_oy <= '0;
    end else if (i_draw) begin
      if (w_x_more) begin
        r_ox <= r_ox + 8'd1;
      end else if (w_y_more) begin
        r_ox <= '0;
        r_oy <= r_oy + 7'd1;
      end
    end
  end

  assign o_x      = r_bx + r_ox;
  assign o_y      = r_by + r_oy;
  assign o_colour = r_col;
endmodule

// File: rtl/pong_datapath.sv
// Pong game state: paddles, ball, miss flag, and the
// shape selection feeding the pixel scanner.
module pong_datapath
  import pong_pkg::*;
#(
  parameter int PAD_STEP = 2,
  parameter int PAD_H    = 16,
  parameter int BALL_SZ  = 4
) (
  input  logic clk,
  input  logic resetn,
  pong_if.slave io_bus
);
  localparam int RHIT_X = RPAD_X - BALL_SZ;

  logic [6:0] r_lpad_y, r_rpad_y, r_ball_y;
  logic [7:0] r_ball_x;
  logic       r_dx, r_dy, r_gameover;

  logic       w_lhit, w_rhit, w_miss, w_yflip;
  logic       w_dx_n, w_dy_n;
  logic [7:0] w_by8, w_lp8, w_rp8;

  logic       w_load, w_draw;
  logic [7:0] w_bx, w_w;
  logic [6:0] w_by, w_h;
  logic [2:0] w_col;

  assign w_by8 = {1'b0, r_ball_y};
  assign w_lp8 = {1'b0, r_lpad_y};
  assign w_rp8 = {1'b0, r_rpad_y};

  // bounce and miss decisions for the current ball
  always_comb begin
    w_lhit = (r_ball_x == 8'(LHIT_X)) && !r_dx
      && (w_by8 + 8'(BALL_SZ - 1) >= w_lp8)
      && (w_by8 <= w_lp8 + 8'(PAD_H - 1));
    w_rhit = (r_ball_x == 8'(RHIT_X)) && r_dx
      && (w_by8 + 8'(BALL_SZ - 1) >= w_rp8)
      && (w_by8 <= w_rp8 + 8'(PAD_H - 1));
    w_miss = ((r_ball_x == 8'd0) && !r_dx)
      || ((r_ball_x == 8'(BALL_X_MAX)) && r_dx);
    w_yflip = ((r_ball_y == 7'd0) && !r_dy)
      || ((r_ball_y == 7'(BALL_Y_MAX)) && r_dy);
    w_dy_n = w_yflip ? ~r_dy : r_dy;
    w_dx_n = r_dx;
    if (w_lhit) w_dx_n = 1'b1;
    if (w_rhit) w_dx_n = 1'b0;
  end

  // game state update, once per move strobe
  always_ff @(posedge clk) begin
    if (!resetn || io_bus.menu) begin
      r_lpad_y   <= 7'(PAD_Y0);
      r_rpad_y   <= 7'(PAD_Y0);
      r_ball_x   <= 8'(BALL_X0);
      r_ball_y   <= 7'(BALL_Y0);
      r_dx       <= 1'b1;
      r_dy       <= 1'b1;
      r_gameover <= 1'b0;
    end else begin
      if (io_bus.move_pads) begin
        r_lpad_y <= pad_next(r_lpad_y,
          io_bus.l_up, io_bus.l_down, PAD_STEP);
        r_rpad_y <= pad_next(r_rpad_y,
          io_bus.r_up, io_bus.r_down, PAD_STEP);
      end
      if (io_bus.move_ball && !r_gameover) begin
        if (w_miss) begin
          r_gameover <= 1'b1;
        end else begin
          r_dx     <= w_dx_n;
          r_dy     <= w_dy_n;
          r_ball_x <= w_dx_n ? r_ball_x + 8'd1
                             : r_ball_x - 8'd1;
          r_ball_y <= w_dy_n ? r_ball_y + 7'd1
                             : r_ball_y - 7'd1;
        end
      end
    end
  end

  // shape selected by whichever load strobe is active
  always_comb begin
    w_bx  = '0;
    w_by  = '0;
    w_w   = '0;
    w_h   = '0;
    w_col = COL_BLACK;
    unique case (1'b1)
      io_bus.set_up_clear_screen: begin
        w_w = 8'(SCR_W);
        w_h = 7'(SCR_H);
      end
      io_bus.load_left_pad: begin
        w_bx  = 8'(LPAD_X);
        w_by  = r_lpad_y;
        w_w   = 8'(PAD_W);
        w_h   = 7'(PAD_H);
        w_col = COL_RED;
      end
      io_bus.load_right_pad: begin
        w_bx  = 8'(RPAD_X);
        w_by  = r_rpad_y;
        w_w   = 8'(PAD_W);
        w_h   = 7'(PAD_H);
        w_col = COL_BLUE;
      end
      io_bus.load_ball: begin
        w_bx  = r_ball_x;
        w_by  = r_ball_y;
        w_w   = 8'(BALL_SZ);
        w_h   = 7'(BALL_SZ);
        w_col = COL_WHITE;
      end
      default: ;
    endcase
  end

  assign w_load = io_bus.set_up_clear_screen
    | io_bus.load_left_pad | io_bus.load_right_pad
    | io_bus.load_ball;
  assign w_draw = io_bus.clear_screen
    | io_bus.draw_left_pad | io_bus.draw_right_pad
    | io_bus.draw_ball;

  pixel_scanner u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .i_zero   (io_bus.menu),
    .i_load   (w_load),
    .i_bx     (w_bx),
    .i_by     (w_by),
    .i_w      (w_w),
    .i_h      (w_h),
    .i_col    (w_col),
    .i_clr    (io_bus.reset_delta),
    .i_draw   (w_draw),
    .o_x      (io_bus.x),
    .o_y      (io_bus.y),
    .o_colour (io_bus.colour)
  );

  assign io_bus.gameover = r_gameover;
endmodule

// File: tb/tb_pong_datapath.sv
// Bench for pong_datapath: directed scans and clamps,
// then randomized play against a rule-level game model.
module tb_pong_datapath;
  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  int m_lpad, m_rpad, m_bx, m_by, m_dx, m_dy, m_go;
  int n_lhit, n_rhit, n_flip, n_games;

  pong_if bus ();

  pong_datapath #(
    .PAD_STEP (2),
    .PAD_H    (16),
    .BALL_SZ  (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.menu = 0;
    bus.move_pads = 0;
    bus.move_ball = 0;
    bus.set_up_clear_screen = 0;
    bus.clear_screen = 0;
    bus.load_left_pad = 0;
    bus.draw_left_pad = 0;
    bus.load_right_pad = 0;
    bus.draw_right_pad = 0;
    bus.load_ball = 0;
    bus.draw_ball = 0;
    bus.reset_delta = 0;
    bus.l_up = 0;
    bus.l_down = 0;
    bus.r_up = 0;
    bus.r_down = 0;
  endtask

  task automatic m_reset();
    m_lpad = 52;
    m_rpad = 52;
    m_bx = 78;
    m_by = 58;
    m_dx = 1;
    m_dy = 1;
    m_go = 0;
  endtask

  function automatic int pad_rule(int y, bit up, bit dn);
    if (up && !dn) return (y - 2 < 0) ? 0 : y - 2;
    if (dn && !up) return (y + 2 > 104) ? 104 : y + 2;
    return y;
  endfunction

  function automatic bit overlap(int by, int py);
    return (by + 3 >= py) && (by <= py + 15);
  endfunction

  task automatic m_ball();
    if (m_go != 0) return;
    if ((m_bx == 0 && m_dx == 0) ||
        (m_bx == 156 && m_dx == 1)) begin
      m_go = 1;
      return;
    end
    if ((m_by == 0 && m_dy == 0) ||
        (m_by == 116 && m_dy == 1)) begin
      m_dy = 1 - m_dy;
      n_flip++;
    end
    if (m_bx == 6 && m_dx == 0 &&
        overlap(m_by, m_lpad)) begin
      m_dx = 1;
      n_lhit++;
    end
    if (m_bx == 150 && m_dx == 1 &&
        overlap(m_by, m_rpad)) begin
      m_dx = 0;
      n_rhit++;
    end
    m_bx += (m_dx != 0) ? 1 : -1;
    m_by += (m_dy != 0) ? 1 : -1;
  endtask

  task automatic do_menu();
    bus.menu = 1;
    tick();
    bus.menu = 0;
    m_reset();
  endtask

  task automatic do_pads(bit lu, bit ld, bit ru, bit rd);
    bus.l_up = lu;
    bus.l_down = ld;
    bus.r_up = ru;
    bus.r_down = rd;
    bus.move_pads = 1;
    tick();
    idle_all();
    m_lpad = pad_rule(m_lpad, lu, ld);
    m_rpad = pad_rule(m_rpad, ru, rd);
  endtask

  task automatic do_ball();
    bus.move_ball = 1;
    tick();
    bus.move_ball = 0;
    m_ball();
  endtask

  task automatic check_ball(input string tag);
    bus.load_ball = 1;
    tick();
    bus.load_ball = 0;
    bus.draw_ball = 1;
    @(negedge clk);
    chk({tag, ".bx"}, bus.x, m_bx);
    chk({tag, ".by"}, bus.y, m_by);
    chk({tag, ".bc"}, bus.colour, 3'b111);
    tick();
    bus.draw_ball = 0;
  endtask

  task automatic check_pads(input string tag);
    bus.load_left_pad = 1;
    tick();
    bus.load_left_pad = 0;
    bus.draw_left_pad = 1;
    @(negedge clk);
    chk({tag, ".lx"}, bus.x, 4);
    chk({tag, ".ly"}, bus.y, m_lpad);
    tick();
    bus.draw_left_pad = 0;
    bus.load_right_pad = 1;
    tick();
    bus.load_right_pad = 0;
    bus.draw_right_pad = 1;
    @(negedge clk);
    chk({tag, ".rx"}, bus.x, 154);
    chk({tag, ".ry"}, bus.y, m_rpad);
    chk({tag, ".rc"}, bus.colour, 3'b001);
    tick();
    bus.draw_right_pad = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    n_lhit = 0;
    n_rhit = 0;
    n_flip = 0;
    n_games = 0;
    idle_all();
    resetn = 0;
    tick();
    tick();
    chk("rst.x", bus.x, 0);
    chk("rst.y", bus.y, 0);
    chk("rst.col", bus.colour, 0);
    chk("rst.go", bus.gameover, 0);
    resetn = 1;
    m_reset();
    tick();
    do_menu();
    chk("menu.x", bus.x, 0);
    chk("menu.y", bus.y, 0);
    chk("menu.go", bus.gameover, 0);
    check_ball("menu");
    check_pads("menu");

    bus.load_left_pad = 1;
    tick();
    bus.load_left_pad = 0;
    bus.draw_left_pad = 1;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("lpad.x", bus.x, (i < 32) ? 4 + i % 2 : 5);
      chk("lpad.y", bus.y,
          (i < 32) ? 52 + i / 2 : 67);
      chk("lpad.c", bus.colour, 3'b100);
      tick();
    end
    bus.draw_left_pad = 0;

    bus.set_up_clear_screen = 1;
    tick();
    bus.set_up_clear_screen = 0;
    bus.clear_screen = 1;
    for (int i = 0; i < 19200; i++) begin
      @(negedge clk);
      chk("clr.x", bus.x, i % 160);
      chk("clr.y", bus.y, i / 160);
      if (i == 0 || i == 19199)
        chk("clr.c", bus.colour, 0);
      tick();
    end
    bus.clear_screen = 0;

    bus.reset_delta = 1;
    tick();
    bus.reset_delta = 0;
    bus.clear_screen = 1;
    @(negedge clk);
    chk("rdelta.x", bus.x, 0);
    chk("rdelta.y", bus.y, 0);
    tick();
    bus.clear_screen = 0;

    for (int i = 0; i < 28; i++) begin
      do_pads(1, 0, 0, 1);
      check_pads("clamp");
    end
    do_pads(1, 1, 1, 1);
    check_pads("both");
    do_pads(0, 0, 0, 0);
    check_pads("none");
    do_menu();

    for (int it = 0; it < 2500; it++) begin
      bit lu, ld, ru, rd;
      if ($urandom_range(99) < 80) begin
        lu = (m_lpad + 6 > m_by);
        ld = !lu;
        ru = (m_rpad + 6 > m_by);
        rd = !ru;
      end else begin
        lu = 1'($urandom_range(1));
        ld = 1'($urandom_range(1));
        ru = 1'($urandom_range(1));
        rd = 1'($urandom_range(1));
      end
      do_pads(lu, ld, ru, rd);
      do_ball();
      chk("play.go", bus.gameover, m_go);
      check_ball("play");
      if (m_go != 0) begin
        n_games++;
        do_ball();
        do_ball();
        check_ball("freeze");
        chk("freeze.go", bus.gameover, 1);
        do_menu();
        chk("menu2.go", bus.gameover, 0);
        check_ball("menu2");
      end
    end

    bus.load_right_pad = 1;
    tick();
    bus.load_right_pad = 0;
    bus.draw_right_pad = 1;
    repeat (5) tick();
    resetn = 0;
    tick();
    chk("midrst.x", bus.x, 0);
    chk("midrst.y", bus.y, 0);
    chk("midrst.c", bus.colour, 0);
    chk("midrst.go", bus.gameover, 0);
    resetn = 1;
    bus.draw_right_pad = 0;
    m_reset();
    check_ball("postrst");

    $display("info: games=%0d lhit=%0d rhit=%0d flips=%0d",
             n_games, n_lhit, n_rhit, n_flip);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_datapath.md
# pong_datapath

Game-state and pixel-generation datapath for VGA Pong. It consumes the one-hot strobes from the Pong control FSM. It holds the paddle and ball positions, updates them once per frame, and flags a missed ball. It also emits one pixel coordinate and colour per cycle to the VGA adapter while a draw strobe is active. Screen is 160×120, 3-bit colour.

## Interface
Parameters:
- PAD_STEP, 2: paddle pixels moved per move_pads strobe.
- PAD_H, 16: paddle height, in pixels.
- BALL_SZ, 4: ball edge length, in pixels.

Ports (reset resetn, synchronous, active-low; clock clk):
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- menu, move_pads, move_ball  in  1 each  control strobes
- set_up_clear_screen, clear_screen  in  1 each  clear-screen load and draw strobes
- load_left_pad, draw_left_pad, load_right_pad, draw_right_pad, load_ball, draw_ball  in  1 each  shape load and draw strobes
- reset_delta  in  1  zero the scan offsets
- l_up, l_down, r_up, r_down  in  1 each  paddle buttons, already synchronised
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  3  pixel colour
- gameover  out  1  sticky miss flag

## Operation
- **State registers:**
  - lpad_y[6:0] and rpad_y[6:0]
  - ball_x[7:0] and ball_y[6:0]
  - dx and dy, 1 bit each: 1 = +1, 0 = −1
  - gameover
- **Reset and menu** (each acts for one cycle and sets identical values): lpad_y = rpad_y = 52, ball_x = 78, ball_y = 58, dx = dy = 1, gameover = 0. Scan registers are zeroed.
- **move_pads:** applied per paddle.
  - up only: y = max(y − PAD_STEP, 0).
  - down only: y = min(y + PAD_STEP, 104).
  - Both buttons or neither: no change.
- **move_ball** (one cycle; no effect while gameover = 1):
  - Vertical: if ball_y = 0 with dy = 0, or ball_y = 116 with dy = 1, flip dy.
  - Left paddle hit: ball_x = 6, dx = 0, ball_y + 3 ≥ lpad_y and ball_y ≤ lpad_y + 15 → dx = 1.
  - Right paddle hit: ball_x = 150, dx = 1, same overlap test against rpad_y → dx = 0.
  - Miss: ball_x = 0 with dx = 0, or ball_x = 156 with dx = 1 → gameover = 1. Position and direction are frozen.
  - Otherwise, after any flips, ball_x += dx′ and ball_y += dy′, using the post-flip directions.
- **Scanner shape loads.** Each load strobe latches base bx/by, width w, height h and colour:
  - set_up_clear_screen: (0, 0), 160×120, colour 000.
  - load_left_pad: (4, lpad_y), 2×16, colour 100.
  - load_right_pad: (154, rpad_y), 2×16, colour 001.
  - load_ball: (ball_x, ball_y), 4×4, colour 111.
- **Scan offsets:** ox[7:0] and oy[6:0] are cleared by reset_delta. Any load strobe also clears them.
- **Draw strobes:** while any draw strobe is high, the offsets advance every cycle in raster order.
  - If ox < w − 1: ox += 1.
  - Else if oy < h − 1: ox = 0, oy += 1.
  - Else: hold, saturating at the last pixel.
- **Outputs:** x = bx + ox, y = by + oy and colour = latched colour are combinational from registers. They are valid whenever a draw strobe is high.

## Timing
- **Reset values:** x = 0, y = 0, colour = 000, gameover = 0.
- **Draw latency:** zero cycles. The pixel presented during a draw cycle is the current offset; the offset advances at the end of that cycle.
- **Shape length:** an N-pixel shape needs N draw cycles. Extra draw cycles re-present the last pixel, which is harmless.
- **gameover:**
  - Registered and sticky.
  - Becomes visible in the cycle after the move_ball that detected the miss.
  - The control FSM acts on it at the next move_ball.
  - Cleared only by menu or reset.
- **Simultaneous strobes** are illegal, since the control FSM is one-hot. If a load and a draw strobe coincide, the load takes priority.
- **Reset mid-scan:** all state is restored to defaults on the next edge.

## Structure
- **pong_pkg:** screen width/height (160/120), PAD_W = 2, left/right paddle columns (4/154), paddle and ball limits (104/116, 156), default positions, and colour constants.
- **pixel_scanner:** the only sub-module. It contains the base/size/colour registers, the ox/oy raster counter, and the x/y/colour outputs.
- **pong_datapath:** holds the game state and the move logic.

## Test plan
- Reset, then menu → lpad_y = rpad_y = 52, ball = (78, 58), dx = dy = 1, gameover = 0, x = y = 0.
- load_left_pad, then 34 draw_left_pad cycles → pixels (4,52), (5,52), (4,53) … (5,67), with colour 100 throughout; cycles 33–34 hold (5,67).
- set_up_clear_screen, then 19200 clear_screen cycles → first pixel (0,0), pixel 160 is (0,1), last pixel (159,119); colour 000 throughout.
- ball_y = 0 with dy = 0, then move_ball → ball_y = 1, dy = 1. ball_y = 116 with dy = 1 → ball_y = 115, dy = 0.
- Paddle hit and miss:
  - Hit: ball (6, 50) with dx = 0 and lpad_y = 52 → dx = 1, ball_x = 7.
  - Miss: same with lpad_y = 80 → ball_x = 5; the ball continues to x = 0.
  - At x = 0, the next move_ball sets gameover = 1 and the ball freezes; menu clears gameover.
- Paddle clamps:
  - l_up held with lpad_y = 1 → 0, then stays 0.
  - r_down held with rpad_y = 103 → 104.
  - l_up and l_down together → no change.
